// File: rtl/sm4_key_arbiter.sv
// Two-requester front end for a single SM4 core: round-robin grants, key (re)load
// only when the owner changes or its key is updated, and bounded bursts per grant.
module sm4_key_arbiter #(
    parameter int P_MAX_BURST = 16,
    parameter int P_CNT_W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key0,
    input  logic [127:0] i_key1,
    input  logic         i_key_upd0,
    input  logic         i_key_upd1,
    input  logic [127:0] i_s0_data,
    input  logic [127:0] i_s1_data,
    input  logic         i_s0_valid,
    input  logic         i_s1_valid,
    output logic         o_s0_ready,
    output logic         o_s1_ready,
    output logic [127:0] o_core_key,
    output logic         o_core_key_valid,
    output logic [127:0] o_core_data,
    output logic         o_core_valid,
    input  logic         i_core_ready,
    input  logic [127:0] i_core_data,
    input  logic         i_core_valid,
    output logic [127:0] o_m_data,
    output logic         o_m_valid,
    output logic         o_m_id,
    output logic         o_busy,
    output logic         o_err
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_KEY, STREAM, DRAIN} state_e;

    localparam logic [7:0] MAXB = 8'(P_MAX_BURST);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 key_owner_q, key_owner_d;
    logic                 key_loaded_q, key_loaded_d;
    logic                 last_q, last_d;
    logic                 wait_first_q, wait_first_d;
    logic [7:0]           burst_q, burst_d;
    logic [P_CNT_W-1:0]   out_q, out_d;
    logic                 err_q, err_d;
    logic [127:0]         core_key_q, core_key_d;

    logic         own_valid, oth_valid, own_upd, gnt, gnt_upd, burst_ok, accept, core_valid;
    logic [127:0] key_sel;

    assign own_valid  = owner_q ? i_s1_valid : i_s0_valid;
    assign oth_valid  = owner_q ? i_s0_valid : i_s1_valid;
    assign own_upd    = owner_q ? i_key_upd1 : i_key_upd0;
    assign key_sel    = owner_q ? i_key1 : i_key0;
    assign gnt        = (i_s0_valid & i_s1_valid) ? ~last_q : i_s1_valid;
    assign gnt_upd    = gnt ? i_key_upd1 : i_key_upd0;
    assign burst_ok   = burst_q < MAXB;
    // Core valid is gated with the burst limit so the core never takes a beat the
    // requester was not handed ready for.
    assign core_valid = (state_q == STREAM) & own_valid & burst_ok;
    assign accept     = core_valid & i_core_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        key_owner_d  = key_owner_q;
        key_loaded_d = key_loaded_q & ~(key_owner_q ? i_key_upd1 : i_key_upd0);
        last_d       = last_q;
        wait_first_d = 1'b0;
        burst_d      = burst_q;
        core_key_d   = core_key_q;
        case (state_q)
            IDLE: begin
                if (i_s0_valid | i_s1_valid) begin
                    owner_d = gnt;
                    if (key_loaded_q && (key_owner_q == gnt) && !gnt_upd) begin
                        state_d = STREAM;
                        last_d  = gnt;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                core_key_d   = key_sel;
                key_owner_d  = owner_q;
                key_loaded_d = ~own_upd;
                wait_first_d = 1'b1;
                state_d      = WAIT_KEY;
            end
            WAIT_KEY: begin
                // Ready in the first cycle still reflects the pre-load core state.
                if (!wait_first_q && i_core_ready) begin
                    state_d = STREAM;
                    last_d  = owner_q;
                end
            end
            STREAM: begin
                burst_d = burst_q + 8'(accept);
                if (own_upd || (!own_valid && oth_valid) || (!burst_ok && oth_valid))
                    state_d = DRAIN;
                else if (!own_valid)
                    state_d = IDLE;
                else if (!burst_ok)
                    burst_d = '0;
            end
            DRAIN: begin
                if ((out_q == '0) && !i_core_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != STREAM)
            burst_d = '0;
    end

    always_comb begin
        out_d = out_q;
        err_d = err_q;
        if (accept && !i_core_valid) begin
            if (&out_q) err_d = 1'b1;
            else        out_d = out_q + P_CNT_W'(1);
        end else if (!accept && i_core_valid) begin
            if (out_q == '0) err_d = 1'b1;
            else             out_d = out_q - P_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            key_owner_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            last_q       <= 1'b1;
            wait_first_q <= 1'b0;
            burst_q      <= '0;
            out_q        <= '0;
            err_q        <= 1'b0;
            core_key_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            key_owner_q  <= key_owner_d;
            key_loaded_q <= key_loaded_d;
            last_q       <= last_d;
            wait_first_q <= wait_first_d;
            burst_q      <= burst_d;
            out_q        <= out_d;
            err_q        <= err_d;
            core_key_q   <= core_key_d;
        end
    end

    assign o_core_key       = (state_q == LOAD) ? key_sel : core_key_q;
    assign o_core_key_valid = (state_q == LOAD);
    assign o_core_data      = owner_q ? i_s1_data : i_s0_data;
    assign o_core_valid     = core_valid;
    assign o_s0_ready       = (state_q == STREAM) & ~owner_q & i_core_ready & burst_ok;
    assign o_s1_ready       = (state_q == STREAM) &  owner_q & i_core_ready & burst_ok;
    assign o_m_data         = i_core_data;
    assign o_m_valid        = i_core_valid;
    assign o_m_id           = key_owner_q;
    assign o_busy           = (state_q != IDLE);
    assign o_err            = err_q;
endmodule
